// File: rtl/riscv8_pkg.sv
// Shared definitions for the 8-bit RISC-V pipeline: data/register widths,
// the memory-mapped LED address, and the MEM/WB pipeline register bundle.
package riscv8_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 5;

  // Full 8-bit address decoded as the LED register when MMIO is built in
  localparam logic [DATA_W-1:0] MMIO_LED_ADDR = 8'hFF;

  // Everything the write-back stage needs, captured at the end of MEM
  typedef struct packed {
    logic [DATA_W-1:0]     read_data;
    logic [DATA_W-1:0]     alu_result;
    logic [REG_ADDR_W-1:0] write_register;
    logic                  mem_to_reg;
    logic                  reg_write;
  } mem_wb_t;

endpackage

// File: rtl/data_memory.sv
// Byte-wide data memory: synchronous write, asynchronous read.
// The array has no reset; contents are undefined until written.
module data_memory #(
  parameter int DEPTH = 256
) (
  input  logic                     clock,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [7:0]               wdata,
  output logic [7:0]               rdata
);

  logic [7:0] mem [DEPTH];

  // Store the write data on the rising edge when the write enable is set
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Reads see the array before any write on the same edge lands
  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 8-bit RISC-V pipeline.
// Resolves branches combinationally, performs data-memory loads/stores, and
// registers the MEM/WB bundle that drives the write-back mux.
// Optional feature: define MEM_MMIO_LED_EN to add an LED output register
// mapped at address 8'hFF (stores update led_out, loads return it).
import riscv8_pkg::*;

module mem_stage #(
  parameter int PC_SIZE = 10,
  parameter int DEPTH   = 256
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PC_SIZE-1:0]    PC_jump,
  input  logic                  zero,
  input  logic [DATA_W-1:0]     ALU_result,
  input  logic [DATA_W-1:0]     write_data,
  input  logic [REG_ADDR_W-1:0] write_register_in,
  input  logic                  branch_in,
  input  logic                  mem_read_in,
  input  logic                  mem_write_in,
  input  logic                  mem_to_reg_in,
  input  logic                  reg_write_in,
  output logic                  pc_src,
  output logic [PC_SIZE-1:0]    branch_target,
  output logic [REG_ADDR_W-1:0] write_register_out,
  output logic                  reg_write_out,
`ifdef MEM_MMIO_LED_EN
  output logic [DATA_W-1:0]     wb_write_data,
  output logic [DATA_W-1:0]     led_out
`else
  output logic [DATA_W-1:0]     wb_write_data
`endif
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] load_value;
  mem_wb_t           mem_wb_q;

  // Upper address bits are dropped so accesses wrap modulo DEPTH
  assign mem_addr = ALU_result[ADDR_W-1:0];

  // Branch decision and target pass straight through; flushing lives in IF/ID
  assign pc_src        = branch_in & zero;
  assign branch_target = PC_jump;

`ifdef MEM_MMIO_LED_EN
  logic              led_hit;
  logic [DATA_W-1:0] led_q;

  // The LED register is decoded on the full 8-bit address, not the wrapped one
  assign led_hit    = (ALU_result == MMIO_LED_ADDR);
  assign mem_we     = mem_write_in & ~led_hit;
  assign load_value = led_hit ? led_q : mem_rdata;
  assign led_out    = led_q;

  // LED register captures stores aimed at its address
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      led_q <= '0;
    end else if (mem_write_in && led_hit) begin
      led_q <= write_data;
    end
  end
`else
  assign mem_we     = mem_write_in;
  assign load_value = mem_rdata;
`endif

  data_memory #(
    .DEPTH (DEPTH)
  ) u_data_memory (
    .clock (clock),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (write_data),
    .rdata (mem_rdata)
  );

  // MEM/WB register; read_data only updates on loads so it holds otherwise,
  // and on a read+write edge it captures the pre-write contents
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_wb_q <= '0;
    end else begin
      mem_wb_q.read_data      <= mem_read_in ? load_value : mem_wb_q.read_data;
      mem_wb_q.alu_result     <= ALU_result;
      mem_wb_q.write_register <= write_register_in;
      mem_wb_q.mem_to_reg     <= mem_to_reg_in;
      mem_wb_q.reg_write      <= reg_write_in;
    end
  end

  // Write-back mux, also feeding the EXE forwarding path
  assign wb_write_data      = mem_wb_q.mem_to_reg ? mem_wb_q.read_data : mem_wb_q.alu_result;
  assign write_register_out = mem_wb_q.write_register;
  assign reg_write_out      = mem_wb_q.reg_write;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: reset, store/load, branch
// resolution, read-during-write, enable-gated read hold, address wrap with a
// 64-byte instance, ALU pass-through, and the optional LED MMIO register.
module tb_mem_stage;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] PC_jump;
  logic       zero;
  logic [7:0] ALU_result;
  logic [7:0] write_data;
  logic [4:0] write_register_in;
  logic       branch_in;
  logic       mem_read_in;
  logic       mem_write_in;
  logic       mem_to_reg_in;
  logic       reg_write_in;

  logic       pc_src;
  logic [9:0] branch_target;
  logic [4:0] write_register_out;
  logic       reg_write_out;
  logic [7:0] wb_write_data;

  logic       pc_src_64;
  logic [9:0] branch_target_64;
  logic [4:0] write_register_out_64;
  logic       reg_write_out_64;
  logic [7:0] wb_write_data_64;

`ifdef MEM_MMIO_LED_EN
  logic [7:0] led_out;
  logic [7:0] led_out_64;
`endif

  int test_count = 0;
  int fail_count = 0;

  always #5 clock = ~clock;

  mem_stage #(.PC_SIZE(10), .DEPTH(256)) dut (
    .clock              (clock),
    .reset              (reset),
    .PC_jump            (PC_jump),
    .zero               (zero),
    .ALU_result         (ALU_result),
    .write_data         (write_data),
    .write_register_in  (write_register_in),
    .branch_in          (branch_in),
    .mem_read_in        (mem_read_in),
    .mem_write_in       (mem_write_in),
    .mem_to_reg_in      (mem_to_reg_in),
    .reg_write_in       (reg_write_in),
    .pc_src             (pc_src),
    .branch_target      (branch_target),
    .write_register_out (write_register_out),
    .reg_write_out      (reg_write_out),
`ifdef MEM_MMIO_LED_EN
    .wb_write_data      (wb_write_data),
    .led_out            (led_out)
`else
    .wb_write_data      (wb_write_data)
`endif
  );

  mem_stage #(.PC_SIZE(10), .DEPTH(64)) dut64 (
    .clock              (clock),
    .reset              (reset),
    .PC_jump            (PC_jump),
    .zero               (zero),
    .ALU_result         (ALU_result),
    .write_data         (write_data),
    .write_register_in  (write_register_in),
    .branch_in          (branch_in),
    .mem_read_in        (mem_read_in),
    .mem_write_in       (mem_write_in),
    .mem_to_reg_in      (mem_to_reg_in),
    .reg_write_in       (reg_write_in),
    .pc_src             (pc_src_64),
    .branch_target      (branch_target_64),
    .write_register_out (write_register_out_64),
    .reg_write_out      (reg_write_out_64),
`ifdef MEM_MMIO_LED_EN
    .wb_write_data      (wb_write_data_64),
    .led_out            (led_out_64)
`else
    .wb_write_data      (wb_write_data_64)
`endif
  );

  // Drive one EX/MEM bundle (branch inputs are driven separately)
  task automatic apply_stimulus(input logic [7:0] alu, input logic [7:0] wdata,
                                input logic rd, input logic wr, input logic m2r,
                                input logic rw, input logic [4:0] wreg);
    ALU_result        = alu;
    write_data        = wdata;
    mem_read_in       = rd;
    mem_write_in      = wr;
    mem_to_reg_in     = m2r;
    reg_write_in      = rw;
    write_register_in = wreg;
  endtask

  // Advance one rising edge and settle just after it
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
    test_count++;
    assert (observed === expected)
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    reset      = 1'b0;
    PC_jump    = '0;
    zero       = 1'b0;
    branch_in  = 1'b0;
    apply_stimulus(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

    // Reset state
    #2;
    check_output("reset_wb_data",  {8'h00, wb_write_data},      16'h0000);
    check_output("reset_reg_write", {15'h0, reg_write_out},     16'h0000);
    check_output("reset_wreg",     {11'h0, write_register_out}, 16'h0000);
    check_output("reset_wb_data_64", {8'h00, wb_write_data_64}, 16'h0000);
`ifdef MEM_MMIO_LED_EN
    check_output("reset_led", {8'h00, led_out}, 16'h0000);
`endif
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Store then load back through the write-back mux
    apply_stimulus(8'h10, 8'h5A, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    apply_stimulus(8'h10, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
    tick();
    check_output("load_5A_data", {8'h00, wb_write_data},      16'h005A);
    check_output("load_5A_rw",   {15'h0, reg_write_out},      16'h0001);
    check_output("load_5A_wreg", {11'h0, write_register_out}, 16'h0003);

    // Branch resolution is combinational
    branch_in = 1'b1;
    zero      = 1'b1;
    PC_jump   = 10'h123;
    #1;
    check_output("branch_taken",  {15'h0, pc_src},       16'h0001);
    check_output("branch_target", {6'h00, branch_target}, 16'h0123);
    zero = 1'b0;
    #1;
    check_output("branch_zero0", {15'h0, pc_src}, 16'h0000);
    branch_in = 1'b0;
    zero      = 1'b1;
    #1;
    check_output("branch_nobranch", {15'h0, pc_src}, 16'h0000);
    zero = 1'b0;

    // Read+write on the same edge captures the old byte
    apply_stimulus(8'h20, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    apply_stimulus(8'h20, 8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4);
    tick();
    check_output("rw_old_data", {8'h00, wb_write_data}, 16'h0011);
    apply_stimulus(8'h20, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4);
    tick();
    check_output("rw_new_data", {8'h00, wb_write_data}, 16'h0022);

    // With mem_read low the read_data register holds its last value
    apply_stimulus(8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5);
    tick();
    check_output("read_hold", {8'h00, wb_write_data},      16'h0022);
    check_output("hold_wreg", {11'h0, write_register_out}, 16'h0005);

    // Address wrap in the 64-byte instance
    apply_stimulus(8'h41, 8'h77, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    apply_stimulus(8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6);
    tick();
    check_output("wrap64_data", {8'h00, wb_write_data_64}, 16'h0077);

    // ALU value passes to write-back when mem_to_reg is low
    apply_stimulus(8'h7E, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'd7);
    tick();
    check_output("alu_pass",    {8'h00, wb_write_data},      16'h007E);
    check_output("alu_pass_rw", {15'h0, reg_write_out},      16'h0001);
    check_output("alu_pass_wreg", {11'h0, write_register_out}, 16'h0007);
    check_output("alu_pass_64", {8'h00, wb_write_data_64},   16'h007E);

`ifdef MEM_MMIO_LED_EN
    // LED register intercepts 8'hFF; the wrapped array byte stays intact
    apply_stimulus(8'h3F, 8'h66, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    apply_stimulus(8'hFF, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    check_output("led_store",    {8'h00, led_out},    16'h00A5);
    check_output("led_store_64", {8'h00, led_out_64}, 16'h00A5);
    apply_stimulus(8'h3F, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8);
    tick();
    check_output("led_array_untouched", {8'h00, wb_write_data_64}, 16'h0066);
    apply_stimulus(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8);
    tick();
    check_output("led_load",    {8'h00, wb_write_data},    16'h00A5);
    check_output("led_load_64", {8'h00, wb_write_data_64}, 16'h00A5);
`else
    // 8'hFF is ordinary memory; in the 64-byte instance it aliases 8'h3F
    apply_stimulus(8'hFF, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    tick();
    apply_stimulus(8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8);
    tick();
    check_output("ff_plain", {8'h00, wb_write_data}, 16'h003C);
    apply_stimulus(8'h3F, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8);
    tick();
    check_output("ff_alias_64", {8'h00, wb_write_data_64}, 16'h003C);
`endif

    // Asynchronous reset mid-cycle clears MEM/WB without a clock edge
    #2;
    reset = 1'b0;
    #1;
    check_output("async_reset_data", {8'h00, wb_write_data},      16'h0000);
    check_output("async_reset_rw",   {15'h0, reg_write_out},      16'h0000);
    check_output("async_reset_wreg", {11'h0, write_register_out}, 16'h0000);
`ifdef MEM_MMIO_LED_EN
    check_output("async_reset_led", {8'h00, led_out}, 16'h0000);
`endif
    @(negedge clock);
    reset = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
